m_mem_rd_conv_m_stm: RTL and testbench
======================================

Name: m_mem_rd_conv_m_stm

Overview:
- AXI4 memory-mapped read master that turns one control command (start address, byte length) into INCR read bursts.
- Returned data is delivered as an AXI-Stream packet, with tlast on the final beat.
- Read-side counterpart of the stream-to-memory write converter; feeds processing pipelines from DDR.
- An internal FIFO buffers read data, and a burst is issued only when the FIFO can absorb all of it.

Parameters:
- MAX_BURST_LEN, 256, maximum beats per AR burst (1..256).
- AXI_ADDR_WIDTH, 32, address width.
- AXI_DATA_WIDTH, 64, data width in bits; bytes per beat B = AXI_DATA_WIDTH/8.
- FIFO_DEPTH, 512, read-data FIFO depth in beats (power of 2, >= MAX_BURST_LEN).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_clr_vld  in  1  clear request (flush FIFO, clear errors)
- o_clr_rdy  out  1  clear may be accepted
- i_ctrl_rd_b_len  in  32  transfer length in bytes
- i_ctrl_rd_addr  in  AXI_ADDR_WIDTH  start address
- i_ctrl_rd_vld  in  1  command valid
- o_ctrl_rd_rdy  out  1  command ready
- m_axis_tdata  out  AXI_DATA_WIDTH  stream data
- m_axis_tlast  out  1  last beat of the command
- m_axis_tvld  out  1  stream valid
- m_axis_trdy  in  1  stream ready
- o_err  out  3  {rlast_err, rresp_err, len_err}, sticky
- m_axi_arready  in  1 ; m_axi_arvalid  out  1 ; m_axi_araddr  out  AXI_ADDR_WIDTH
- m_axi_arlen  out  BitWidth(MAX_BURST_LEN-1)  beats-1
- m_axi_rvalid  in  1 ; m_axi_rready  out  1 ; m_axi_rdata  in  AXI_DATA_WIDTH ; m_axi_rresp  in  2 ; m_axi_rlast  in  1
- m_axi_arburst  out  2 ; m_axi_arcache  out  4 ; m_axi_arlock  out  1 ; m_axi_arprot  out  3 ; m_axi_arqos  out  4 ; m_axi_arsize  out  3 ; m_axi_arregion  out  4

Behaviour:
- Reset:
  - All registered outputs are 0 during reset, including o_ctrl_rd_rdy, o_clr_rdy, arvalid, rready and o_err.
  - FIFO is empty and m_axis_tvld = 0.
  - In the first cycle after reset: state IDLE, o_ctrl_rd_rdy = 1, o_clr_rdy = 1.
  - Reset mid-burst abandons the burst; the interconnect must be reset together with this block.
- Static AR fields: arburst = 1 (INCR), arcache = 3, arsize = clog2(B), all others 0.
- Length conversion: total beats N = ceil(b_len / B), computed from b_len[31:log2 B] plus 1 if the remainder bits are nonzero.
- Burst length: burst beats L = min(N_remaining, MAX_BURST_LEN); arlen = L-1.
- Address step: after each burst, addr += L << log2(B).
- FSM:
  - IDLE, command handshake:
    - Latch address and N; drop ctrl_rdy.
    - If N == 0: set len_err, stay in IDLE, ctrl_rdy = 1 next cycle.
    - Otherwise go to WAIT_SPACE.
  - WAIT_SPACE: when FIFO free >= L, assert arvalid and go to RD_ADDR; clr_rdy = 0.
  - RD_ADDR: hold arvalid/araddr/arlen stable until arready. On handshake: arvalid = 0, beat counter = L, rready = 1, go to RD_DATA.
  - RD_DATA, each r handshake:
    - Push {tlast, rdata} to the FIFO; counter decrements.
    - rresp != 0 sets rresp_err.
    - rlast must coincide with counter == 1, else set rlast_err.
    - The burst ends on the counter's last beat regardless of rlast.
  - End of burst:
    - rready = 0; N_remaining -= L.
    - If N_remaining == 0: go to IDLE with ctrl_rdy = 1.
    - Otherwise go to WAIT_SPACE with clr_rdy = 1.
- Outstanding bursts: exactly one at a time, so FIFO free space can never underflow. rready is held high for the whole burst.
- Stream tlast: FIFO tlast = 1 only on the last beat of the last burst of the command.
- Stream timing: FIFO is first-word-fall-through; m_axis_tvld = !empty. Read-data-to-stream latency is 1 cycle.
- Back-to-back commands: a new command may be accepted in IDLE while the FIFO is still draining.
- Clear:
  - i_clr_vld & o_clr_rdy, in IDLE or WAIT_SPACE: flush the FIFO and zero o_err next cycle; go to IDLE.
  - The command in progress is abandoned.
  - A clear arriving in the same cycle as a command in IDLE wins; the command is not accepted.

Optional Feature:
- Macro: M_MEM_RD_BURST_4K_EN.
- When defined: L = min(N_remaining, MAX_BURST_LEN, (4096 - addr[11:0]) / B), so no burst crosses a 4 KB boundary.
- When undefined: L = min(N_remaining, MAX_BURST_LEN); the start address is required to keep bursts within 4 KB.

Decomposition:
- Package mem_rd_pkg holds:
  - the Fsm_e enum (IDLE, WAIT_SPACE, RD_ADDR, RD_DATA);
  - the BitWidth function;
  - the err-bit index constants;
  - the AXI static-field constants (INCR, cache 3).
- Sub-module sync_fwft_fifo: inferred memory, width AXI_DATA_WIDTH+1, depth FIFO_DEPTH, synchronous flush, free-count output.

Test Plan:
- b_len=2048, addr=0x1000_0000, B=8 -> one AR with arlen=255 at 0x1000_0000; 256 stream beats; tlast only on beat 256; ctrl_rdy returns after rlast.
- b_len=4100 -> N=513; ARs arlen 255/255/0 at 0x1000_0000, 0x1000_0800, 0x1000_1000; tlast on beat 513.
- b_len=13 -> arlen=1, 2 beats; b_len=0 -> o_err=3'b001, no AR, ctrl_rdy high next cycle.
- m_axis_trdy=0, b_len=8192 -> two 256-beat bursts fill the FIFO; third AR stays blocked until 256 beats are drained.
- rresp=2 on beat 5, and rlast early on beat 100 of 256 -> o_err=3'b110 sticky; i_clr_vld in IDLE -> o_err=0, FIFO empty.
- M_MEM_RD_BURST_4K_EN, addr=0x0F80, b_len=1024 -> ARs arlen=15 at 0x0F80, then arlen=111 at 0x1000.

Source files
------------

// File: rtl/m_mem_rd_conv_m_stm_pkg.sv
// mem_rd_pkg: shared FSM type, error bit indices and AXI constants for the read-to-stream converter
package mem_rd_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_SPACE, RD_ADDR, RD_DATA} Fsm_e;
  localparam int LEN_ERR = 0;
  localparam int RRESP_ERR = 1;
  localparam int RLAST_ERR = 2;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE = 4'b0011;
  function automatic int BitWidth(input int x);
    return x < 2 ? 1 : $clog2(x + 1);
  endfunction
endpackage

// File: rtl/m_mem_rd_conv_m_stm_if.sv
// m_mem_rd_conv_m_stm_if: AXI4 read address and read data channels
interface m_mem_rd_conv_m_stm_if
  import mem_rd_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W = BitWidth(255)
);
  logic arready, arvalid, arlock;
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0] arlen;
  logic [1:0] arburst;
  logic [3:0] arcache, arqos, arregion;
  logic [2:0] arprot, arsize;
  logic rvalid, rready, rlast;
  logic [DATA_W-1:0] rdata;
  logic [1:0] rresp;
  modport master(
    input arready, rvalid, rdata, rresp, rlast,
    output arvalid, araddr, arlen, arburst, arcache, arlock, arprot, arqos, arsize, arregion, rready
  );
  modport slave(
    output arready, rvalid, rdata, rresp, rlast,
    input arvalid, araddr, arlen, arburst, arcache, arlock, arprot, arqos, arsize, arregion, rready
  );
endinterface

// File: rtl/m_mem_rd_conv_m_stm_fifo.sv
// sync_fwft_fifo: first-word-fall-through FIFO with synchronous flush and free-slot count
module sync_fwft_fifo #(
  parameter int W = 65,
  parameter int DEPTH = 512
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic flush,
  input  logic push,
  input  logic [W-1:0] din,
  input  logic pop,
  output logic [W-1:0] dout,
  output logic empty,
  output logic [$clog2(DEPTH):0] free
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = wr_ptr == rd_ptr;
  assign free = (AW+1)'(DEPTH) - (wr_ptr - rd_ptr);
  assign do_push = push & (free != '0);
  assign do_pop = pop & !empty;
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge i_clk)
    if (i_rst | flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(do_push);
      rd_ptr <= rd_ptr + (AW+1)'(do_pop);
    end
  always_ff @(posedge i_clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/m_mem_rd_conv_m_stm.sv
// m_mem_rd_conv_m_stm: AXI4 read master turning (addr, byte length) commands into an AXI-Stream packet
// Define M_MEM_RD_BURST_4K_EN to split bursts at 4 KB address boundaries.
module m_mem_rd_conv_m_stm
  import mem_rd_pkg::*;
#(
  parameter int MAX_BURST_LEN = 256,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 512
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr_vld,
  output logic o_clr_rdy,
  input  logic [31:0] i_ctrl_rd_b_len,
  input  logic [AXI_ADDR_WIDTH-1:0] i_ctrl_rd_addr,
  input  logic i_ctrl_rd_vld,
  output logic o_ctrl_rd_rdy,
  output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic m_axis_tlast,
  output logic m_axis_tvld,
  input  logic m_axis_trdy,
  output logic [2:0] o_err,
  m_mem_rd_conv_m_stm_if.master m_axi
);
  localparam int LB = $clog2(AXI_DATA_WIDTH / 8);
  localparam int CW = BitWidth(MAX_BURST_LEN);
  localparam int LW = BitWidth(MAX_BURST_LEN - 1);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  Fsm_e state;
  logic [AXI_ADDR_WIDTH-1:0] addr;
  logic [31:0] n_rem, n_cmd, lim, l_nxt;
  logic [CW-1:0] blen, cnt;
  logic [FW-1:0] free;
  logic empty, clr_acc, cmd_acc, push, last_beat, last_burst;
  assign n_cmd = (i_ctrl_rd_b_len >> LB) + 32'(|i_ctrl_rd_b_len[LB-1:0]);
`ifdef M_MEM_RD_BURST_4K_EN
  logic [31:0] lim_4k;
  assign lim_4k = (32'd4096 - 32'(addr[11:0])) >> LB;
  assign lim = lim_4k < 32'(MAX_BURST_LEN) ? lim_4k : 32'(MAX_BURST_LEN);
`else
  assign lim = 32'(MAX_BURST_LEN);
`endif
  assign l_nxt = n_rem < lim ? n_rem : lim;
  assign clr_acc = i_clr_vld & o_clr_rdy & (state == IDLE | state == WAIT_SPACE);
  assign cmd_acc = i_ctrl_rd_vld & o_ctrl_rd_rdy & (state == IDLE) & !clr_acc;
  assign push = (state == RD_DATA) & m_axi.rvalid & m_axi.rready;
  assign last_beat = cnt == CW'(1);
  assign last_burst = n_rem == 32'(blen);
  assign m_axis_tvld = !empty;
  assign m_axi.araddr = addr;
  assign m_axi.arburst = AXI_BURST_INCR;
  assign m_axi.arcache = AXI_CACHE;
  assign m_axi.arsize = 3'(LB);
  assign m_axi.arlock = 1'b0;
  assign m_axi.arprot = 3'b000;
  assign m_axi.arqos = 4'b0000;
  assign m_axi.arregion = 4'b0000;
  // One burst in flight at a time, so reserving L slots before AR guarantees no overflow.
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state <= IDLE;
      addr <= '0;
      n_rem <= '0;
      blen <= '0;
      cnt <= '0;
      o_ctrl_rd_rdy <= 1'b0;
      o_clr_rdy <= 1'b0;
      o_err <= '0;
      m_axi.arvalid <= 1'b0;
      m_axi.arlen <= '0;
      m_axi.rready <= 1'b0;
    end else if (clr_acc) begin
      state <= IDLE;
      o_err <= '0;
      o_ctrl_rd_rdy <= 1'b1;
      o_clr_rdy <= 1'b1;
    end else case (state)
      IDLE:
        if (cmd_acc) begin
          addr <= i_ctrl_rd_addr;
          n_rem <= n_cmd;
          o_ctrl_rd_rdy <= n_cmd == '0;
          if (n_cmd == '0) o_err[LEN_ERR] <= 1'b1;
          else state <= WAIT_SPACE;
        end else begin
          o_ctrl_rd_rdy <= 1'b1;
          o_clr_rdy <= 1'b1;
        end
      WAIT_SPACE:
        if (32'(free) >= l_nxt) begin
          m_axi.arvalid <= 1'b1;
          m_axi.arlen <= LW'(l_nxt - 32'd1);
          blen <= CW'(l_nxt);
          o_clr_rdy <= 1'b0;
          state <= RD_ADDR;
        end
      RD_ADDR:
        if (m_axi.arready) begin
          m_axi.arvalid <= 1'b0;
          cnt <= blen;
          m_axi.rready <= 1'b1;
          state <= RD_DATA;
        end
      RD_DATA:
        if (push) begin
          cnt <= cnt - CW'(1);
          if (m_axi.rresp != 2'b00) o_err[RRESP_ERR] <= 1'b1;
          if (m_axi.rlast != last_beat) o_err[RLAST_ERR] <= 1'b1;
          if (last_beat) begin
            m_axi.rready <= 1'b0;
            n_rem <= n_rem - 32'(blen);
            addr <= addr + (AXI_ADDR_WIDTH'(blen) << LB);
            o_ctrl_rd_rdy <= last_burst;
            o_clr_rdy <= 1'b1;
            state <= last_burst ? IDLE : WAIT_SPACE;
          end
        end
    endcase
  sync_fwft_fifo #(.W(AXI_DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .flush(clr_acc),
    .push(push),
    .din({last_beat & last_burst, m_axi.rdata}),
    .pop(m_axis_tvld & m_axis_trdy),
    .dout({m_axis_tlast, m_axis_tdata}),
    .empty(empty),
    .free(free)
  );
endmodule

// File: tb/tb_m_mem_rd_conv_m_stm.sv
// tb_m_mem_rd_conv_m_stm: directed bench with an AXI read slave model returning each beat's address as data
module tb_m_mem_rd_conv_m_stm;
  import mem_rd_pkg::*;
  logic clk = 0, rst = 1;
  logic clr_vld = 0, clr_rdy, ctrl_vld = 0, ctrl_rdy, tlast, tvld, trdy = 0;
  logic [31:0] b_len = 0, addr = 0;
  logic [63:0] tdata;
  logic [2:0] err;
  int checks = 0, errors = 0;
  logic [31:0] ar_a[$];
  int ar_l[$];
  logic [63:0] s_data[$];
  logic s_last[$];
  logic [31:0] cur = 0;
  int left = 0, bnum = 0, inj_resp = 0, inj_last = 0;

  m_mem_rd_conv_m_stm_if #(.ADDR_W(32), .DATA_W(64), .LEN_W(8)) bus();

  m_mem_rd_conv_m_stm #(
    .MAX_BURST_LEN(256), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .FIFO_DEPTH(512)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_clr_vld(clr_vld), .o_clr_rdy(clr_rdy),
    .i_ctrl_rd_b_len(b_len), .i_ctrl_rd_addr(addr), .i_ctrl_rd_vld(ctrl_vld),
    .o_ctrl_rd_rdy(ctrl_rdy), .m_axis_tdata(tdata), .m_axis_tlast(tlast),
    .m_axis_tvld(tvld), .m_axis_trdy(trdy), .o_err(err), .m_axi(bus)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Slave decides at each falling edge what the next rising edge will transfer.
  initial begin
    bus.arready = 0; bus.rvalid = 0; bus.rdata = '0; bus.rresp = 0; bus.rlast = 0;
    forever begin
      @(negedge clk);
      if (left > 0) begin
        bus.rvalid = 1;
        bus.rdata = {32'd0, cur};
        bus.rresp = (bnum == inj_resp) ? 2'd2 : 2'd0;
        bus.rlast = (left == 1) || (bnum == inj_last);
        if (bus.rready) begin
          cur += 8;
          left--;
          bnum++;
        end
      end else bus.rvalid = 0;
      bus.arready = bus.arvalid;
      if (bus.arvalid) begin
        ar_a.push_back(bus.araddr);
        ar_l.push_back(int'(bus.arlen));
        cur = bus.araddr;
        left = int'(bus.arlen) + 1;
        bnum = 1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    #1;
    if (tvld && trdy) begin
      s_data.push_back(tdata);
      s_last.push_back(tlast);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] l);
    int t = 0;
    while (!ctrl_rdy && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_rdy_wait", t < 5000, 1);
    ar_a.delete();
    ar_l.delete();
    addr = a;
    b_len = l;
    ctrl_vld = 1;
    @(negedge clk);
    ctrl_vld = 0;
  endtask

  task automatic wait_done(input int n);
    int t = 0;
    while ((s_data.size() < n || !ctrl_rdy) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    chk("done_wait", t < 5000, 1);
  endtask

  task automatic drain(input int n);
    int t = 0;
    while (s_data.size() < n && t < 2000) begin
      trdy = 1;
      @(negedge clk);
      t++;
    end
    trdy = 0;
    chk("drain_wait", t < 2000, 1);
  endtask

  task automatic chk_stream(input string tag, input logic [31:0] base, input int n);
    int bad_d = 0, bad_l = 0;
    chk({tag, "_beats"}, s_data.size(), n);
    foreach (s_data[i]) begin
      if (s_data[i] !== {32'd0, base + 32'(i * 8)}) bad_d++;
      if (s_last[i] !== (i == n - 1)) bad_l++;
    end
    chk({tag, "_data_bad"}, bad_d, 0);
    chk({tag, "_tlast_bad"}, bad_l, 0);
    s_data.delete();
    s_last.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ctrl_rdy", ctrl_rdy, 0);
    chk("rst_clr_rdy", clr_rdy, 0);
    chk("rst_tvld", tvld, 0);
    chk("rst_err", err, 0);
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_rready", bus.rready, 0);
    rst = 0;
    @(negedge clk);
    chk("post_rst_ctrl_rdy", ctrl_rdy, 1);
    chk("post_rst_clr_rdy", clr_rdy, 1);
    chk("arburst", bus.arburst, 1);
    chk("arcache", bus.arcache, 3);
    chk("arsize", bus.arsize, 3);
    chk("arprot", bus.arprot, 0);

    trdy = 1;
    send(32'h1000_0000, 2048);
    wait_done(256);
    chk("t1_ar_n", ar_a.size(), 1);
    chk("t1_araddr", ar_a[0], 32'h1000_0000);
    chk("t1_arlen", ar_l[0], 255);
    chk_stream("t1", 32'h1000_0000, 256);

    send(32'h1000_0000, 4100);
    wait_done(513);
    chk("t2_ar_n", ar_a.size(), 3);
    chk("t2_araddr0", ar_a[0], 32'h1000_0000);
    chk("t2_araddr1", ar_a[1], 32'h1000_0800);
    chk("t2_araddr2", ar_a[2], 32'h1000_1000);
    chk("t2_arlen0", ar_l[0], 255);
    chk("t2_arlen1", ar_l[1], 255);
    chk("t2_arlen2", ar_l[2], 0);
    chk_stream("t2", 32'h1000_0000, 513);

    send(32'h1000_0000, 13);
    wait_done(2);
    chk("t3_ar_n", ar_a.size(), 1);
    chk("t3_arlen", ar_l[0], 1);
    chk_stream("t3", 32'h1000_0000, 2);

    send(32'h1000_0000, 0);
    chk("len0_ctrl_rdy", ctrl_rdy, 1);
    chk("len0_err", err, 3'b001);
    repeat (5) @(negedge clk);
    chk("len0_no_ar", ar_a.size(), 0);
    chk("len0_clr_rdy", clr_rdy, 1);
    clr_vld = 1;
    @(negedge clk);
    clr_vld = 0;
    chk("len0_err_cleared", err, 0);

    trdy = 0;
    send(32'h2000_0000, 8192);
    repeat (700) @(negedge clk);
    chk("bp_ar_two", ar_a.size(), 2);
    chk("bp_no_beats", s_data.size(), 0);
    chk("bp_tvld", tvld, 1);
    drain(255);
    repeat (20) @(negedge clk);
    chk("bp_ar_still_blocked", ar_a.size(), 2);
    drain(256);
    repeat (5) @(negedge clk);
    chk("bp_ar_released", ar_a.size(), 3);
    chk("bp_araddr2", ar_a[2], 32'h2000_1000);
    trdy = 1;
    wait_done(1024);
    chk("bp_ar_n", ar_a.size(), 4);
    chk_stream("bp", 32'h2000_0000, 1024);

    inj_resp = 5;
    inj_last = 100;
    send(32'h3000_0000, 2048);
    wait_done(256);
    inj_resp = 0;
    inj_last = 0;
    chk("err_resp_last", err, 3'b110);
    chk_stream("err", 32'h3000_0000, 256);
    trdy = 0;
    send(32'h3000_1000, 16);
    wait_done(0);
    chk("err_sticky", err, 3'b110);
    chk("pre_clr_tvld", tvld, 1);
    addr = 32'h4000_0000;
    b_len = 64;
    ctrl_vld = 1;
    clr_vld = 1;
    @(negedge clk);
    ctrl_vld = 0;
    clr_vld = 0;
    chk("clr_err", err, 0);
    chk("clr_flush", tvld, 0);
    chk("clr_ctrl_rdy", ctrl_rdy, 1);
    ar_a.delete();
    ar_l.delete();
    repeat (10) @(negedge clk);
    chk("clr_wins_no_ar", ar_a.size(), 0);
    s_data.delete();
    s_last.delete();

    trdy = 1;
`ifdef M_MEM_RD_BURST_4K_EN
    send(32'h0000_0F80, 1024);
    wait_done(128);
    chk("k4_ar_n", ar_a.size(), 2);
    chk("k4_araddr0", ar_a[0], 32'h0000_0F80);
    chk("k4_arlen0", ar_l[0], 15);
    chk("k4_araddr1", ar_a[1], 32'h0000_1000);
    chk("k4_arlen1", ar_l[1], 111);
    chk_stream("k4", 32'h0000_0F80, 128);
`else
    send(32'h2000_0100, 1000);
    wait_done(125);
    chk("t7_ar_n", ar_a.size(), 1);
    chk("t7_araddr", ar_a[0], 32'h2000_0100);
    chk("t7_arlen", ar_l[0], 124);
    chk_stream("t7", 32'h2000_0100, 125);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
